// File: rtl/rbcp_wb_pkg.sv
// Shared definitions for the RBCP-to-Wishbone bridge.
//   state_t    : bridge FSM states
//   lane_bits  : number of byte-lane address bits for a given Wishbone data width
//   cnt_width  : register width able to hold 0..n (never narrower than 1 bit)
package rbcp_wb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_BUS     = 2'd1,
        ST_BACKOFF = 2'd2,
        ST_RESP    = 2'd3
    } state_t;

    function automatic int lane_bits(input int dw);
        return $clog2(dw / 8);
    endfunction

    function automatic int cnt_width(input int n);
        return (n < 1) ? 1 : $clog2(n + 1);
    endfunction

endpackage

// File: rtl/rbcp_wb_lane.sv
// Byte-lane steering between the 8-bit RBCP side and the DW-bit Wishbone side.
// Purely combinational.
//   lane     in   LW    byte-lane index (low address bits)
//   wd       in   8     RBCP write byte
//   dat_i    in   DW    Wishbone read data
//   sel      out  DW/8  one-hot byte select (all ones for an 8-bit bus)
//   dat_o    out  DW    write byte replicated on every lane
//   rd_byte  out  8     byte picked from dat_i by lane
module rbcp_wb_lane
    import rbcp_wb_pkg::*;
#(
    parameter  int DW   = 32,
    localparam int LB   = lane_bits(DW),
    localparam int LW   = (LB > 0) ? LB : 1,
    localparam int SELW = DW / 8
) (
    input  logic [LW-1:0]   lane,
    input  logic [7:0]      wd,
    input  logic [DW-1:0]   dat_i,
    output logic [SELW-1:0] sel,
    output logic [DW-1:0]   dat_o,
    output logic [7:0]      rd_byte
);

    assign dat_o = {SELW{wd}};

    generate
        if (LB == 0) begin : g_byte_bus
            assign sel     = '1;
            assign rd_byte = dat_i[7:0];
        end else begin : g_multi_lane
            assign sel     = SELW'(1) << lane;
            assign rd_byte = dat_i[{lane, 3'b000} +: 8];
        end
    endgenerate

endmodule

// File: rtl/rbcp_wb_bridge.sv
// RBCP-to-Wishbone classic master bridge with retry, timeout and error reporting.
// Each single-byte RBCP access becomes one Wishbone cycle (re-issued after wb_rty
// up to MAX_RETRY times); the outcome is returned as a one-cycle rbcp_ack pulse
// qualified by rbcp_err.
//   clk, rst                 clock, synchronous active-high reset
//   rbcp_act/we/re/addr/wd   RBCP request side
//   rbcp_rd/ack/err          RBCP response side
//   wb_adr/dat_o/cyc/stb/we/sel   Wishbone master outputs
//   wb_dat_i/ack/err/rty          Wishbone slave responses
module rbcp_wb_bridge
    import rbcp_wb_pkg::*;
#(
    parameter int AW        = 16,
    parameter int DW        = 32,
    parameter int TIMEOUT   = 255,
    parameter int MAX_RETRY = 3
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            rbcp_act,
    input  logic            rbcp_we,
    input  logic            rbcp_re,
    input  logic [AW-1:0]   rbcp_addr,
    input  logic [7:0]      rbcp_wd,
    output logic [7:0]      rbcp_rd,
    output logic            rbcp_ack,
    output logic            rbcp_err,
    output logic [AW-1:0]   wb_adr,
    output logic [DW-1:0]   wb_dat_o,
    input  logic [DW-1:0]   wb_dat_i,
    output logic            wb_cyc,
    output logic            wb_stb,
    output logic            wb_we,
    output logic [DW/8-1:0] wb_sel,
    input  logic            wb_ack,
    input  logic            wb_err,
    input  logic            wb_rty
);

    localparam int LB   = lane_bits(DW);
    localparam int LW   = (LB > 0) ? LB : 1;
    localparam int TW   = cnt_width(TIMEOUT);
    localparam int RW   = cnt_width(MAX_RETRY);
    localparam int SELW = DW / 8;

    localparam logic [AW-1:0] LANE_MASK = AW'(SELW - 1);
    localparam logic [TW-1:0] TMO_LAST  = TW'(TIMEOUT - 1);
    localparam logic [RW-1:0] RTY_MAX   = RW'(MAX_RETRY);

    state_t          state, state_d;
    logic [AW-1:0]   addr_q;
    logic [7:0]      wd_q;
    logic            we_q;
    logic [7:0]      rd_q;
    logic            err_q;
    logic [TW-1:0]   tmo_cnt;
    logic [RW-1:0]   rty_cnt;

    logic            start;
    logic [SELW-1:0] lane_sel;
    logic [DW-1:0]   lane_dat;
    logic [7:0]      lane_rd;

    // A strobe counts only while the RBCP transaction is active; we&re is a write.
    assign start = (rbcp_we | rbcp_re) & rbcp_act;

    rbcp_wb_lane #(
        .DW (DW)
    ) u_lane (
        .lane    (addr_q[LW-1:0]),
        .wd      (wd_q),
        .dat_i   (wb_dat_i),
        .sel     (lane_sel),
        .dat_o   (lane_dat),
        .rd_byte (lane_rd)
    );

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_d;
        end
    end

    // Next-state logic; termination priority in BUS is act-drop, ack, err, rty, timeout.
    always_comb begin
        state_d = state;
        unique case (state)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_BUS;
                end
            end
            ST_BUS: begin
                if (!rbcp_act) begin
                    state_d = ST_IDLE;
                end else if (wb_ack || wb_err) begin
                    state_d = ST_RESP;
                end else if (wb_rty) begin
                    state_d = (rty_cnt < RTY_MAX) ? ST_BACKOFF : ST_RESP;
                end else if (tmo_cnt == TMO_LAST) begin
                    state_d = ST_RESP;
                end
            end
            ST_BACKOFF: begin
                state_d = rbcp_act ? ST_BUS : ST_IDLE;
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Request latches, outcome capture and counters
    always_ff @(posedge clk) begin
        if (rst) begin
            addr_q  <= '0;
            wd_q    <= '0;
            we_q    <= 1'b0;
            rd_q    <= '0;
            err_q   <= 1'b0;
            tmo_cnt <= '0;
            rty_cnt <= '0;
        end else begin
            if (state == ST_IDLE && start) begin
                addr_q <= rbcp_addr;
                wd_q   <= rbcp_wd;
                we_q   <= rbcp_we;
            end

            // Leaving BUS for RESP: only a wb_ack is a success (ack has top priority).
            if (state == ST_BUS && state_d == ST_RESP) begin
                err_q <= ~wb_ack;
                rd_q  <= (wb_ack && !we_q) ? lane_rd : 8'h00;
            end

            // Timeout window restarts on every (re-)issue of the cycle.
            if (state == ST_BUS && state_d == ST_BUS) begin
                tmo_cnt <= tmo_cnt + 1'b1;
            end else begin
                tmo_cnt <= '0;
            end

            // Retry count survives BACKOFF; cleared once the access is over.
            if (state == ST_BUS && state_d == ST_BACKOFF) begin
                rty_cnt <= rty_cnt + 1'b1;
            end else if (state == ST_IDLE || state == ST_RESP) begin
                rty_cnt <= '0;
            end
        end
    end

    // Outputs; address/data/sel/we stay put across BACKOFF gaps.
    always_comb begin
        logic busy;
        busy     = (state == ST_BUS) || (state == ST_BACKOFF);
        wb_cyc   = (state == ST_BUS);
        wb_stb   = (state == ST_BUS);
        wb_we    = busy & we_q;
        wb_sel   = busy ? lane_sel : '0;
        wb_adr   = addr_q & ~LANE_MASK;
        wb_dat_o = lane_dat;
        rbcp_ack = (state == ST_RESP);
        rbcp_err = (state == ST_RESP) & err_q;
        rbcp_rd  = (state == ST_RESP) ? rd_q : 8'h00;
    end

endmodule

// File: tb/tb_rbcp_wb_bridge.sv
module tb_rbcp_wb_bridge;

    localparam int AW = 16;
    localparam int DW = 32;

    typedef struct packed {
        logic       err;
        logic [7:0] rd;
    } resp_t;

    logic          clk;
    logic          rst;
    logic          rbcp_act, rbcp_we, rbcp_re;
    logic [AW-1:0] rbcp_addr;
    logic [7:0]    rbcp_wd;
    logic [7:0]    rbcp_rd;
    logic          rbcp_ack, rbcp_err;
    logic [AW-1:0] wb_adr;
    logic [DW-1:0] wb_dat_o, wb_dat_i;
    logic          wb_cyc, wb_stb, wb_we;
    logic [3:0]    wb_sel;
    logic          wb_ack, wb_err, wb_rty;

    int    tests = 0;
    int    fails = 0;
    resp_t exp_q[$];

    rbcp_wb_bridge #(
        .AW(AW), .DW(DW), .TIMEOUT(8), .MAX_RETRY(3)
    ) dut (
        .clk(clk), .rst(rst),
        .rbcp_act(rbcp_act), .rbcp_we(rbcp_we), .rbcp_re(rbcp_re),
        .rbcp_addr(rbcp_addr), .rbcp_wd(rbcp_wd),
        .rbcp_rd(rbcp_rd), .rbcp_ack(rbcp_ack), .rbcp_err(rbcp_err),
        .wb_adr(wb_adr), .wb_dat_o(wb_dat_o), .wb_dat_i(wb_dat_i),
        .wb_cyc(wb_cyc), .wb_stb(wb_stb), .wb_we(wb_we), .wb_sel(wb_sel),
        .wb_ack(wb_ack), .wb_err(wb_err), .wb_rty(wb_rty)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Called at a negedge where a response is due: pops the scoreboard and compares.
    task automatic resp_now(input string tag);
        resp_t e;
        check({tag, "_ack"}, 64'(rbcp_ack), 64'd1);
        if (exp_q.size() == 0) begin
            tests++;
            fails++;
            $error("FAIL %s_sb: observed response, expected none queued", tag);
        end else begin
            e = exp_q.pop_front();
            check({tag, "_err"}, 64'(rbcp_err), 64'(e.err));
            check({tag, "_rd"}, 64'(rbcp_rd), 64'(e.rd));
        end
    endtask

    task automatic idle_check(input string tag, input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            check(tag, {62'd0, wb_cyc, rbcp_ack}, 64'd0);
        end
    endtask

    // Drives a one-cycle strobe; returns just after the edge that sampled it.
    task automatic strobe(input logic we, input logic re, input logic [AW-1:0] a, input logic [7:0] d);
        @(posedge clk); #1;
        rbcp_we = we; rbcp_re = re; rbcp_addr = a; rbcp_wd = d;
        @(posedge clk); #1;
        rbcp_we = 1'b0; rbcp_re = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_ctl"}, 64'({wb_cyc, wb_stb, wb_we, wb_sel, rbcp_ack, rbcp_err, rbcp_rd}), 64'd0);
        check({tag, "_dat"}, 64'({wb_adr, wb_dat_o}), 64'd0);
    endtask

    initial begin
        int cyc_n, gap_n, bad;
        rst = 1'b1; rbcp_act = 1'b1; rbcp_we = 1'b0; rbcp_re = 1'b0;
        rbcp_addr = '0; rbcp_wd = '0; wb_dat_i = '0;
        wb_ack = 1'b0; wb_err = 1'b0; wb_rty = 1'b0;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_all_zero("reset");
        @(posedge clk); #1; rst = 1'b0;

        // Write 0x1235 <- 0xA5, ack three cycles after the strobe
        strobe(1'b1, 1'b0, 16'h1235, 8'hA5);
        exp_q.push_back('{err: 1'b0, rd: 8'h00});
        @(negedge clk);
        check("wr_cyc", 64'({wb_cyc, wb_stb, wb_we}), 64'b111);
        check("wr_adr", 64'(wb_adr), 64'h1234);
        check("wr_sel", 64'(wb_sel), 64'b0010);
        check("wr_dat", 64'(wb_dat_o), 64'hA5A5A5A5);
        @(posedge clk); #1;
        @(posedge clk); #1; wb_ack = 1'b1;
        @(posedge clk); #1; wb_ack = 1'b0;
        @(negedge clk);
        resp_now("wr");
        check("wr_cyc_off", 64'(wb_cyc), 64'd0);

        // Read 0x0043, top lane
        strobe(1'b0, 1'b1, 16'h0043, 8'h00);
        exp_q.push_back('{err: 1'b0, rd: 8'h11});
        @(negedge clk);
        check("rd_sel", 64'(wb_sel), 64'b1000);
        check("rd_adr_we", 64'({wb_adr, wb_we}), 64'({16'h0040, 1'b0}));
        wb_dat_i = 32'h11223344; wb_ack = 1'b1;
        @(posedge clk); #1; wb_ack = 1'b0;
        @(negedge clk);
        resp_now("rd");

        // Retry exhausted: rty on every issue
        strobe(1'b1, 1'b0, 16'h2002, 8'h3C);
        exp_q.push_back('{err: 1'b1, rd: 8'h00});
        wb_rty = 1'b1;
        cyc_n = 0; gap_n = 0; bad = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (rbcp_ack) break;
            if (wb_cyc) cyc_n++; else gap_n++;
            if (wb_sel !== 4'b0100 || wb_we !== 1'b1 || wb_adr !== 16'h2000 || wb_dat_o !== 32'h3C3C3C3C) bad++;
        end
        wb_rty = 1'b0;
        resp_now("rty4");
        check("rty4_cyc_n", 64'(cyc_n), 64'd4);
        check("rty4_gap_n", 64'(gap_n), 64'd3);
        check("rty4_stable", 64'(bad), 64'd0);

        // Two retries, then success on lane 1
        wb_dat_i = 32'h00005A00;
        strobe(1'b0, 1'b1, 16'h0001, 8'h00);
        exp_q.push_back('{err: 1'b0, rd: 8'h5A});
        wb_rty = 1'b1;
        cyc_n = 0; gap_n = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (rbcp_ack) break;
            if (wb_cyc) begin
                cyc_n++;
                if (cyc_n < 3) begin wb_rty = 1'b1; wb_ack = 1'b0; end
                else           begin wb_rty = 1'b0; wb_ack = 1'b1; end
            end else begin
                gap_n++; wb_rty = 1'b0; wb_ack = 1'b0;
            end
        end
        wb_ack = 1'b0; wb_rty = 1'b0;
        resp_now("rty2");
        check("rty2_cyc_n", 64'(cyc_n), 64'd3);
        check("rty2_gap_n", 64'(gap_n), 64'd2);

        // Silent slave: timeout after exactly 8 cycles of cyc
        strobe(1'b0, 1'b1, 16'h0010, 8'h00);
        exp_q.push_back('{err: 1'b1, rd: 8'h00});
        cyc_n = 0; gap_n = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (rbcp_ack) break;
            if (wb_cyc) cyc_n++; else gap_n++;
        end
        resp_now("tmo");
        check("tmo_cyc_n", 64'(cyc_n), 64'd8);
        check("tmo_gap_n", 64'(gap_n), 64'd0);

        // Slave error
        strobe(1'b0, 1'b1, 16'h0020, 8'h00);
        exp_q.push_back('{err: 1'b1, rd: 8'h00});
        wb_err = 1'b1; wb_dat_i = 32'hFFFFFFFF;
        @(posedge clk); #1; wb_err = 1'b0;
        @(negedge clk);
        resp_now("werr");

        // rbcp_act dropped while in BUS: abort, no ack
        strobe(1'b1, 1'b0, 16'h0050, 8'h12);
        rbcp_act = 1'b0;
        @(negedge clk);
        check("abort_cyc_before", 64'(wb_cyc), 64'd1);
        idle_check("abort_idle", 3);
        rbcp_act = 1'b1;
        wb_dat_i = 32'h00CD0000;
        strobe(1'b0, 1'b1, 16'h0052, 8'h00);
        exp_q.push_back('{err: 1'b0, rd: 8'hCD});
        wb_ack = 1'b1;
        @(posedge clk); #1; wb_ack = 1'b0;
        @(negedge clk);
        resp_now("after_abort");

        // Strobe with rbcp_act low is ignored
        rbcp_act = 1'b0;
        strobe(1'b1, 1'b0, 16'h0060, 8'h01);
        idle_check("noact", 3);
        rbcp_act = 1'b1;

        // Reset in the middle of BUS drops the access
        strobe(1'b1, 1'b0, 16'h0123, 8'h99);
        @(negedge clk);
        check("rst_cyc_before", 64'(wb_cyc), 64'd1);
        @(posedge clk); #1; rst = 1'b1; wb_ack = 1'b1;
        @(posedge clk); #1; rst = 1'b0; wb_ack = 1'b0;
        @(negedge clk);
        check_all_zero("rst_mid");
        idle_check("rst_idle", 3);

        // we&re together is a write; a strobe while busy adds nothing
        strobe(1'b1, 1'b1, 16'h0107, 8'h77);
        exp_q.push_back('{err: 1'b0, rd: 8'h00});
        @(negedge clk);
        check("wr_re_we", 64'(wb_we), 64'd1);
        check("wr_re_sel", 64'(wb_sel), 64'b1000);
        check("wr_re_dat", 64'(wb_dat_o), 64'h77777777);
        @(posedge clk); #1; rbcp_re = 1'b1; rbcp_addr = 16'h0200;
        @(posedge clk); #1; rbcp_re = 1'b0;
        @(negedge clk);
        check("busy_adr", 64'(wb_adr), 64'h0104);
        wb_ack = 1'b1;
        @(posedge clk); #1; wb_ack = 1'b0;
        @(negedge clk);
        resp_now("wr_re");
        idle_check("busy_strobe", 4);

        check("sb_empty", 64'(exp_q.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
